// File: rtl/adc_avg_capture.sv
// rtl/adc_avg_capture.sv - multi-pass triggered ADC capture with averaged AXI-Stream readout
// Optional feature macro: ADC_CAP_ROUND_EN (round-half-up averaging; floor when undefined)
module adc_avg_capture #(
    parameter int  SAMPLE_W         = 16,
    parameter int  SAMPLES_PER_WORD = 8,
    parameter int  DEPTH            = 16,
    parameter int  MAX_SHIFT        = 4,
    localparam int ACC_W            = SAMPLE_W + MAX_SHIFT,
    localparam int CYC_W            = $clog2(DEPTH + 1),
    localparam int SHIFT_W          = $clog2(MAX_SHIFT + 1)
) (
    input  logic                                 pl_clk,
    input  logic                                 rst,
    input  logic [CYC_W-1:0]                     cfg_run_cycles,
    input  logic [SHIFT_W-1:0]                   cfg_shift,
    input  logic                                 arm,
    input  logic                                 trigger,
    input  logic                                 abort,
    input  logic [SAMPLE_W*SAMPLES_PER_WORD-1:0] s_axis_tdata,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    output logic [2*SAMPLE_W-1:0]                m_axis_tdata,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 cfg_err
);
    localparam int PAIRS  = SAMPLES_PER_WORD / 2;
    localparam int PAIR_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PC_W   = MAX_SHIFT + 1;
    localparam logic [CYC_W-1:0]   DEPTH_C     = CYC_W'(DEPTH);
    localparam logic [SHIFT_W-1:0] MAX_SHIFT_C = SHIFT_W'(MAX_SHIFT);
    localparam logic [PAIR_W-1:0]  LAST_PAIR   = PAIR_W'(PAIRS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_READOUT} state_t;
    state_t state, state_nx;

    logic [CYC_W-1:0]   run_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [PC_W-1:0]    pass_cnt;
    logic [CYC_W-1:0]   word_idx;
    logic [CYC_W-1:0]   rd_word;
    logic [PAIR_W-1:0]  rd_pair;
    logic               rd_more;

    logic signed [ACC_W-1:0] acc [DEPTH][SAMPLES_PER_WORD];
    logic signed [ACC_W-1:0] lane_ext [SAMPLES_PER_WORD];
    logic signed [ACC_W-1:0] rd_acc [2];
    logic signed [ACC_W:0]   rd_sum [2];
    logic [SAMPLE_W-1:0]     rd_avg [2];
    logic [ACC_W:0]          round_add;

    logic cfg_ok, arm_ok, word_acc, last_word, last_pass, rd_load, rd_last_beat, last_hs;

    assign s_axis_tready = 1'b1;
    assign busy          = (state != S_IDLE);

    assign cfg_ok       = (cfg_run_cycles != '0) && (cfg_run_cycles <= DEPTH_C) && (cfg_shift <= MAX_SHIFT_C);
    assign arm_ok       = (state == S_IDLE) && arm && cfg_ok;
    assign word_acc     = (state == S_CAPTURE) && s_axis_tvalid;
    assign last_word    = word_acc && (word_idx == run_q - CYC_W'(1));
    assign last_pass    = (pass_cnt + PC_W'(1)) == (PC_W'(1) << shift_q);
    assign rd_load      = (state == S_READOUT) && rd_more && (!m_axis_tvalid || m_axis_tready);
    assign rd_last_beat = (rd_word == run_q - CYC_W'(1)) && (rd_pair == LAST_PAIR);
    assign last_hs      = (state == S_READOUT) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // State register
    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state logic; abort overrides every other event
    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (arm_ok) state_nx = S_ARMED;
                S_ARMED:   if (trigger) state_nx = S_CAPTURE;
                S_CAPTURE: if (last_word) state_nx = last_pass ? S_READOUT : S_ARMED;
                S_READOUT: if (last_hs) state_nx = S_IDLE;
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    // Latched configuration, pass counter and capture word index
    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            run_q    <= '0;
            shift_q  <= '0;
            pass_cnt <= '0;
            word_idx <= '0;
        end else if (!abort) begin
            case (state)
                S_IDLE: begin
                    if (arm_ok) begin
                        run_q    <= cfg_run_cycles;
                        shift_q  <= cfg_shift;
                        pass_cnt <= '0;
                    end
                end
                S_ARMED: if (trigger) word_idx <= '0;
                S_CAPTURE: begin
                    if (word_acc) begin
                        if (last_word) begin
                            word_idx <= '0;
                            pass_cnt <= pass_cnt + PC_W'(1);
                        end else begin
                            word_idx <= word_idx + CYC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Sign-extend each incoming lane to accumulator width
    always_comb begin
        for (int i = 0; i < SAMPLES_PER_WORD; i++) begin
            lane_ext[i] = {{MAX_SHIFT{s_axis_tdata[i*SAMPLE_W + SAMPLE_W - 1]}}, s_axis_tdata[i*SAMPLE_W +: SAMPLE_W]};
        end
    end

    // Accumulators: first pass overwrites, so no reset or clearing is needed
    always_ff @(posedge pl_clk) begin
        if (word_acc) begin
            for (int i = 0; i < SAMPLES_PER_WORD; i++) begin
                if (pass_cnt == '0) acc[word_idx[IDX_W-1:0]][i] <= lane_ext[i];
                else                acc[word_idx[IDX_W-1:0]][i] <= acc[word_idx[IDX_W-1:0]][i] + lane_ext[i];
            end
        end
    end

    // Select the lane pair for the current readout beat and scale to an average
    always_comb begin
        rd_acc[0] = '0;
        rd_acc[1] = '0;
        for (int i = 0; i < SAMPLES_PER_WORD; i++) begin
            if (i == 2 * int'(rd_pair))     rd_acc[0] = acc[rd_word[IDX_W-1:0]][i];
            if (i == 2 * int'(rd_pair) + 1) rd_acc[1] = acc[rd_word[IDX_W-1:0]][i];
        end
        round_add = '0;
`ifdef ADC_CAP_ROUND_EN
        if (shift_q != '0) round_add = (ACC_W+1)'(1) << (shift_q - SHIFT_W'(1));
`endif
        for (int j = 0; j < 2; j++) begin
            rd_sum[j] = {rd_acc[j][ACC_W-1], rd_acc[j]} + round_add;
            rd_avg[j] = SAMPLE_W'(rd_sum[j] >>> shift_q);
        end
    end

    // Output register: one fill cycle on entry, then one beat per ready cycle
    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            rd_word       <= '0;
            rd_pair       <= '0;
            rd_more       <= 1'b0;
        end else if (abort || state != S_READOUT) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            rd_word       <= '0;
            rd_pair       <= '0;
            rd_more       <= 1'b1;
        end else if (rd_load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= {rd_avg[1], rd_avg[0]};
            m_axis_tlast  <= rd_last_beat;
            if (rd_last_beat) rd_more <= 1'b0;
            if (rd_pair == LAST_PAIR) begin
                rd_pair <= '0;
                rd_word <= rd_word + CYC_W'(1);
            end else begin
                rd_pair <= rd_pair + PAIR_W'(1);
            end
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end

    // Single-cycle status pulses
    always_ff @(posedge pl_clk or negedge rst) begin
        if (!rst) begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            done    <= last_hs && !abort;
            cfg_err <= (state == S_IDLE) && arm && !cfg_ok && !abort;
        end
    end
endmodule
